// File: rtl/uart_fifo_core.sv
// uart_fifo_core: buffered 8N1 UART. A TX FIFO feeds a serializer, and a
// deserializer feeds an RX FIFO with a show-ahead read port.
//
// Ports:
//   clk, rst         single clock, async active-high reset
//   tx_byte/transmit push one byte per asserted cycle into the TX FIFO
//   tx_fifo_full/tx_fifo_empty, is_transmitting, busy   TX status
//   tx               serial output, idles high
//   rx               serial input, asynchronous to clk
//   rx_fifo_pop      pop strobe; rx_byte is the head of the RX FIFO
//   rx_fifo_empty, irq (= RX FIFO non-empty)
//
// Both serial FSMs use the same states:
//   state | meaning
//   IDLE  | TX: waiting for a queued byte / RX: waiting for a low level
//   START | start bit (RX: half-bit wait then glitch re-check)
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (RX: sample it, push byte if it is high)

module uart_fifo_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is refused even if a pop happens alongside it.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  // Head is forced to zero when empty so the read port never shows stale data.
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end
endmodule

module uart_fifo_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       tx_fifo_full,
  output logic       tx_fifo_empty,
  output logic       is_transmitting,
  output logic       busy,
  output logic       tx,
  input  logic       rx,
  input  logic       rx_fifo_pop,
  output logic [7:0] rx_byte,
  output logic       rx_fifo_empty,
  output logic       irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  logic [7:0] tx_head;
  logic       tx_pop, rx_push;

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(transmit), .wdata(tx_byte), .pop(tx_pop),
    .rdata(tx_head), .full(tx_fifo_full), .empty(tx_fifo_empty)
  );

  // ---------------- TX serializer ----------------
  uart_state_t   tx_state, tx_state_next;
  logic [CW-1:0] tx_cnt, tx_cnt_next;
  logic [7:0]    tx_shreg, tx_shreg_next;
  logic [2:0]    tx_bit, tx_bit_next;
  logic          tx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_shreg <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_cnt   <= tx_cnt_next;
      tx_shreg <= tx_shreg_next;
      tx_bit   <= tx_bit_next;
      tx       <= tx_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt;
    tx_shreg_next = tx_shreg;
    tx_bit_next   = tx_bit;
    tx_next       = tx;
    tx_pop        = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        if (!tx_fifo_empty) begin
          tx_pop        = 1'b1;
          tx_shreg_next = tx_head;
          tx_next       = 1'b0;
          tx_cnt_next   = BIT_LAST;
          tx_state_next = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt == '0) begin
          tx_next       = tx_shreg[0];
          tx_cnt_next   = BIT_LAST;
          tx_bit_next   = 3'd0;
          tx_state_next = ST_DATA;
        end else begin
          tx_cnt_next = tx_cnt - CW'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_next = BIT_LAST;
          if (tx_bit == 3'd7) begin
            tx_next       = 1'b1;
            tx_state_next = ST_STOP;
          end else begin
            // tx_shreg[0] is the bit on the line; the next one is bit 1.
            tx_next       = tx_shreg[1];
            tx_shreg_next = {1'b0, tx_shreg[7:1]};
            tx_bit_next   = tx_bit + 3'd1;
          end
        end else begin
          tx_cnt_next = tx_cnt - CW'(1);
        end
      end
      ST_STOP: begin
        if (tx_cnt == '0) tx_state_next = ST_IDLE;
        else              tx_cnt_next   = tx_cnt - CW'(1);
      end
      default: tx_state_next = ST_IDLE;
    endcase
  end

  assign is_transmitting = (tx_state != ST_IDLE);
  assign busy            = is_transmitting | ~tx_fifo_empty;

  // ---------------- RX deserializer ----------------
  uart_state_t   rx_state, rx_state_next;
  logic [CW-1:0] rx_cnt, rx_cnt_next;
  logic [7:0]    rx_shreg, rx_shreg_next;
  logic [2:0]    rx_bit, rx_bit_next;
  logic          rx_meta, rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_shreg <= '0;
      rx_bit   <= '0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_next;
      rx_cnt   <= rx_cnt_next;
      rx_shreg <= rx_shreg_next;
      rx_bit   <= rx_bit_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_next   = rx_cnt;
    rx_shreg_next = rx_shreg;
    rx_bit_next   = rx_bit;
    rx_push       = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (!rx_sync) begin
          rx_cnt_next   = HALF_LAST;
          rx_state_next = ST_START;
        end
      end
      ST_START: begin
        // Half a bit in: still low means a real start bit, and every later
        // sample lands mid-bit.
        if (rx_cnt == '0) begin
          if (rx_sync) begin
            rx_state_next = ST_IDLE;
          end else begin
            rx_cnt_next   = BIT_LAST;
            rx_bit_next   = 3'd0;
            rx_state_next = ST_DATA;
          end
        end else begin
          rx_cnt_next = rx_cnt - CW'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt == '0) begin
          rx_shreg_next = {rx_sync, rx_shreg[7:1]};
          rx_cnt_next   = BIT_LAST;
          if (rx_bit == 3'd7) rx_state_next = ST_STOP;
          else                rx_bit_next   = rx_bit + 3'd1;
        end else begin
          rx_cnt_next = rx_cnt - CW'(1);
        end
      end
      ST_STOP: begin
        if (rx_cnt == '0) begin
          rx_push       = rx_sync;
          rx_state_next = ST_IDLE;
        end else begin
          rx_cnt_next = rx_cnt - CW'(1);
        end
      end
      default: rx_state_next = ST_IDLE;
    endcase
  end

  logic rx_fifo_full_unused;

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_shreg), .pop(rx_fifo_pop),
    .rdata(rx_byte), .full(rx_fifo_full_unused), .empty(rx_fifo_empty)
  );

  assign irq = ~rx_fifo_empty;
endmodule

// File: tb/tb_uart_fifo_core.sv
module tb_uart_fifo_core;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       transmit = 1'b0;
  logic       rx = 1'b1;
  logic       rx_fifo_pop = 1'b0;
  logic       tx_fifo_full, tx_fifo_empty, is_transmitting, busy, tx;
  logic [7:0] rx_byte;
  logic       rx_fifo_empty, irq;

  uart_fifo_core #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .transmit(transmit),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .is_transmitting(is_transmitting), .busy(busy), .tx(tx), .rx(rx),
    .rx_fifo_pop(rx_fifo_pop), .rx_byte(rx_byte),
    .rx_fifo_empty(rx_fifo_empty), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int rx_model_cnt = 0;
  logic [7:0] burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] rx_burst [5] = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hE5};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Checks one frame on tx, cycle by cycle, against the head of tx_q.
  // Entered and left on a negedge; leaves one cycle past the 10th bit.
  task automatic tx_frame(input bit chk_gap);
    int         waited = 0;
    logic [7:0] exp;
    logic [9:0] bits;
    logic [CPB-1:0] seen;
    while (tx !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      timeout_fail("tx_start_wait");
      return;
    end
    if (chk_gap) check("tx_interframe_gap", waited, 1);
    if (tx_q.size() == 0) begin
      timeout_fail("tx_unexpected_frame");
      return;
    end
    exp  = tx_q.pop_front();
    bits = {1'b1, exp, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        seen[c] = tx;
        @(negedge clk);
      end
      check($sformatf("tx_%02h_bit%0d", exp, b), seen, {CPB{bits[b]}});
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    if (stop && rx_model_cnt < DEPTH) begin
      rx_q.push_back(b);
      rx_model_cnt++;
    end
  endtask

  task automatic wait_irq();
    int w = 0;
    while (irq !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("irq_rise", irq, 1);
  endtask

  task automatic rx_pop();
    logic [7:0] exp;
    if (rx_q.size() == 0) begin
      timeout_fail("rx_pop_model_empty");
      return;
    end
    exp = rx_q.pop_front();
    check("rx_irq_before_pop", irq, 1);
    check($sformatf("rx_byte_%02h", exp), rx_byte, exp);
    rx_fifo_pop = 1'b1;
    @(negedge clk);
    rx_fifo_pop = 1'b0;
    rx_model_cnt--;
  endtask

  initial begin
    // Reset held with transmit asserted: nothing may be queued.
    rst = 1'b1;
    transmit = 1'b1;
    tx_byte = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_is_tx", is_transmitting, 0);
    check("rst_full", tx_fifo_full, 0);
    check("rst_tx_empty", tx_fifo_empty, 1);
    check("rst_rx_empty", rx_fifo_empty, 1);
    check("rst_irq", irq, 0);
    check("rst_rx_byte", rx_byte, 8'h00);
    transmit = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_empty", tx_fifo_empty, 1);
    check("post_rst_tx", tx, 1);

    // Single byte 0xA5: accept on E0, start bit after E1.
    tx_byte = 8'hA5;
    transmit = 1'b1;
    tx_q.push_back(8'hA5);
    @(negedge clk);
    transmit = 1'b0;
    check("e0_tx_empty", tx_fifo_empty, 0);
    check("e0_busy", busy, 1);
    check("e0_tx", tx, 1);
    check("e0_is_tx", is_transmitting, 0);
    @(negedge clk);
    check("e1_tx", tx, 0);
    check("e1_is_tx", is_transmitting, 1);
    tx_frame(1'b0);
    check("a5_busy_after", busy, 0);
    check("a5_tx_idle", tx, 1);
    check("a5_is_tx_after", is_transmitting, 0);

    // Six pushes back to back: first byte leaves after one cycle, so the
    // FIFO fills on the 5th push and the 6th is dropped.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          tx_byte = burst[i];
          transmit = 1'b1;
          if (i < 5) tx_q.push_back(burst[i]);
          @(negedge clk);
          check($sformatf("burst_full_%0d", i), tx_fifo_full, (i >= 4) ? 1 : 0);
        end
        transmit = 1'b0;
      end
      begin
        tx_frame(1'b0);
        for (int k = 0; k < 4; k++) tx_frame(1'b1);
      end
    join
    check("burst_busy_after", busy, 0);
    check("burst_tx_empty_after", tx_fifo_empty, 1);
    check("burst_full_after", tx_fifo_full, 0);

    // RX single frame and pop.
    repeat (2) @(negedge clk);
    send_rx(8'h3C, 1'b1);
    wait_irq();
    rx_pop();
    check("rx_irq_after_pop", irq, 0);
    check("rx_byte_after_pop", rx_byte, 8'h00);

    // Framing error then a one-cycle glitch: nothing received.
    send_rx(8'h55, 1'b0);
    repeat (12) @(negedge clk);
    check("framing_err_irq", irq, 0);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_irq", irq, 0);
    check("glitch_rx_empty", rx_fifo_empty, 1);

    // Five frames with no pops: RX FIFO keeps the first four.
    for (int i = 0; i < 5; i++) begin
      send_rx(rx_burst[i], 1'b1);
      repeat (2) @(negedge clk);
    end
    check("rx_overflow_model_cnt", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) rx_pop();
    check("rx_drained_irq", irq, 0);
    check("rx_drained_empty", rx_fifo_empty, 1);
    rx_fifo_pop = 1'b1;
    @(negedge clk);
    rx_fifo_pop = 1'b0;
    check("rx_pop_when_empty", rx_fifo_empty, 1);

    // Reset in the middle of a frame: tx returns high at once.
    tx_byte = 8'h00;
    transmit = 1'b1;
    @(negedge clk);
    transmit = 1'b0;
    repeat (6) @(negedge clk);
    check("midframe_tx_low", tx, 0);
    rst = 1'b1;
    #1;
    check("midframe_rst_tx", tx, 1);
    check("midframe_rst_busy", busy, 0);
    check("midframe_rst_is_tx", is_transmitting, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("after_abort_tx", tx, 1);
    check("after_abort_tx_empty", tx_fifo_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Buffered 8N1 UART: a transmit FIFO feeding a serializer and a deserializer feeding a receive FIFO. It sits behind the APB UART peripheral. The bus wrapper pushes bytes with `transmit` and back-pressures the bus on `tx_fifo_full`. Received bytes are popped through a show-ahead read port.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, default 8: entries per FIFO; power of two, ≥ 2.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_byte`  in  8  byte to enqueue for transmission.
- `transmit`  in  1  push strobe; one byte per asserted cycle.
- `tx_fifo_full`  out  1  TX FIFO holds `FIFO_DEPTH` bytes.
- `tx_fifo_empty`  out  1  TX FIFO holds no bytes.
- `is_transmitting`  out  1  serializer is mid-frame.
- `busy`  out  1  `is_transmitting | !tx_fifo_empty`.
- `tx`  out  1  serial output; idles high.
- `rx`  in  1  serial input; asynchronous.
- `rx_fifo_pop`  in  1  pop strobe for the RX FIFO.
- `rx_byte`  out  8  head of the RX FIFO (show-ahead).
- `rx_fifo_empty`  out  1  RX FIFO holds no bytes.
- `irq`  out  1  `!rx_fifo_empty`.

## Operation
**Reset values:** `tx`=1, `busy`=0, `is_transmitting`=0, `tx_fifo_full`=0, `tx_fifo_empty`=1, `rx_fifo_empty`=1, `irq`=0, `rx_byte`=0. Both FIFOs are emptied. Reset mid-frame aborts the frame immediately; `tx` returns high.

**FIFOs**
- Circular buffers with read/write pointers and an occupancy count of width log2(`FIFO_DEPTH`)+1.
- Pointers wrap modulo `FIFO_DEPTH`.
- Full when count = `FIFO_DEPTH`; empty when count = 0.
- A push while full is dropped and the contents are unchanged. A pop while empty is ignored.
- Simultaneous push and pop in one cycle: both take effect and the count is unchanged.
- A push into a full FIFO is rejected even if a pop occurs in the same cycle.

**TX serializer FSM (IDLE, START, DATA, STOP)**
- IDLE: if the TX FIFO is non-empty, pop the head into the shift register, drive `tx`=0 and go to START.
- START: hold for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: shift out 8 bits, LSB first, `CLKS_PER_BIT` cycles each.
- STOP: drive `tx`=1 for `CLKS_PER_BIT` cycles, then return to IDLE.
- `is_transmitting` = 1 in every state except IDLE.

**RX deserializer FSM (IDLE, START, DATA, STOP)**
- `rx` passes through a 2-flop synchronizer; all decisions use the synchronized value.
- IDLE: a low level starts the START state.
- START: after `CLKS_PER_BIT/2` cycles, re-sample. If high, treat as a glitch and return to IDLE; if low, go to DATA.
- DATA: sample 8 bits at `CLKS_PER_BIT` intervals, i.e. at mid-bit, assembling LSB first.
- STOP: sample after one more `CLKS_PER_BIT`. If 1, push the byte into the RX FIFO, subject to the overflow rule. If 0, discard the byte as a framing error. Either way, return to IDLE.

## Timing
- Push accepted on edge E0: `tx_fifo_empty` falls and `busy` rises after E0.
- On E1 the serializer pops the byte; `tx` falls and `is_transmitting` rises after E1.
- Frame length: start bit + 8 data bits + stop bit, each `CLKS_PER_BIT` cycles.
- A queued next byte has its start bit begin one cycle after STOP ends; the effective stop bit is `CLKS_PER_BIT`+1 cycles.
- `busy` falls the cycle after the last stop bit ends, provided the FIFO is empty.
- `tx_fifo_full` updates the cycle after the push that fills the FIFO and clears the cycle after the pop that frees a slot.
- RX latency: the byte appears on `rx_byte` and `irq` rises one cycle after the stop-bit sample cycle.
- After a pop, `rx_byte` shows the next entry on the following cycle.

## Test plan
All cases use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset held with `transmit`=1 → `tx`=1, `busy`=0, no push, both FIFOs empty.
- Push 0xA5 → after E1, `tx` shows 0,1,0,1,0,0,1,0,1,1, 4 cycles each; `busy` drops after the stop bit.
- Push 6 bytes on consecutive cycles → `tx_fifo_full`=1 while 4 bytes are queued; the 6th byte is dropped. Output is bytes 1–5, back-to-back, with a 5-cycle stop bit between frames.
- Drive `rx` with frame 0x3C → `irq`=1 and `rx_byte`=0x3C. Pulse `rx_fifo_pop` → `irq`=0.
- Drive `rx` frame 0x55 with stop bit 0 → byte discarded, `irq` stays 0. Drive a 1-cycle low glitch on `rx` → no byte received.
- Receive 5 frames without popping → first 4 are stored and the 5th is dropped. Pop 4 times → `rx_byte` sequence matches the order received.
